bcd_to_bin: RTL and testbench

//   Sequential multi-digit packed-BCD to unsigned-binary converter (reverse double-dabble).

---
 rtl/bcd_to_bin_if.sv | 24 ++
 rtl/bcd_to_bin.sv | 108 ++++++++++
 tb/tb_bcd_to_bin.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_to_bin_if.sv
// Handshake bundle for the packed-BCD to binary converter.
// The master issues start/bcd_in; the slave (converter) returns status and the result.
interface bcd_to_bin_if #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic [BIN_W-1:0]      bin_out;
  logic                  err;

  modport master (
    output start, bcd_in,
    input  ready, busy, done, bin_out, err
  );

  modport slave (
    input  start, bcd_in,
    output ready, busy, done, bin_out, err
  );
endinterface

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to unsigned-binary converter (reverse double-dabble, one bit per cycle).
// Optional invalid-digit detection on accept is enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_to_bin #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  bcd_to_bin_if.slave  bus
);
  localparam int unsigned NB = 4 * DIGITS;
  localparam int unsigned CW = $clog2(NB + 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StConv = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [NB-1:0]      bcd_q, bin_q;
  logic [NB-1:0]      bcd_nx, bin_nx;
  logic [2*NB-1:0]    sh;
  logic [CW-1:0]      cnt_q;
  logic [BIN_W-1:0]   bin_out_q;
  logic               err_q;
  logic               last;
  logic               bad_digit;

  assign last = (cnt_q == CW'(NB - 1));

`ifdef BCD_DIGIT_CHECK_EN
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end
`else
  assign bad_digit = 1'b0;
`endif

  // One reverse double-dabble step: shift right, then pull every digit >= 8 back by 3.
  always_comb begin
    sh     = {bcd_q, bin_q} >> 1;
    bcd_nx = sh[2*NB-1:NB];
    bin_nx = sh[NB-1:0];
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_nx[4*i+3]) bcd_nx[4*i +: 4] = bcd_nx[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.start) state_d = bad_digit ? StDone : StConv;
      end
      StConv: begin
        if (last) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            bcd_q <= bus.bcd_in;
            bin_q <= '0;
            cnt_q <= '0;
            if (bad_digit) begin
              bin_out_q <= '0;
              err_q     <= 1'b1;
            end
          end
        end
        StConv: begin
          bcd_q <= bcd_nx;
          bin_q <= bin_nx;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            bin_out_q <= bin_nx[BIN_W-1:0];
            err_q     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready   = (state_q == StIdle);
  assign bus.busy    = (state_q == StConv);
  assign bus.done    = (state_q == StDone);
  assign bus.bin_out = bin_out_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: scoreboard of expected {err, bin_out} checked on done.
module tb_bcd_to_bin;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  logic [14:0] sbq[$];
  logic [14:0] mon_exp;

  bcd_to_bin_if #(.DIGITS(4), .BIN_W(14)) bif ();

  bcd_to_bin #(.DIGITS(4), .BIN_W(14)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  // Reference: decimal value of the packed digits, err clear.
  function automatic logic [14:0] model(input logic [15:0] b);
    int v;
    v = 0;
    for (int i = 3; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return {1'b0, 14'(v)};
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && bif.done === 1'b1) begin
      total++;
      done_cnt++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got bin_out=%0d err=%b, required no done pulse",
                 bif.bin_out, bif.err);
      end else begin
        mon_exp = sbq.pop_front();
        if ({bif.err, bif.bin_out} !== mon_exp) begin
          bad++;
          $display("FAIL result: got bin_out=%0d err=%b, required bin_out=%0d err=%b",
                   bif.bin_out, bif.err, mon_exp[13:0], mon_exp[14]);
        end
      end
    end
  end

  // Called just after a negedge with the DUT idle; start is sampled on the next posedge.
  task automatic drive_start(input logic [15:0] v, input bit push, input logic [14:0] e);
    bif.start  = 1'b1;
    bif.bcd_in = v;
    if (push) sbq.push_back(e);
    @(posedge clk);
    #1 bif.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bif.start  = 1'b0;
    bif.bcd_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (bif.ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b, required 1", bif.ready); end
    total++; if (bif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", bif.busy); end
    total++; if (bif.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b, required 0", bif.done); end
    total++; if (bif.bin_out !== 14'd0) begin bad++; $display("FAIL reset_bin: got %0d, required 0", bif.bin_out); end
    total++; if (bif.err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b, required 0", bif.err); end
  endtask

  task automatic test_basic();
    int n, n_busy;
    logic [14:0] e;
    e = model(16'h1234);
    drive_start(16'h1234, 1'b1, e);
    bif.bcd_in = 16'h9999;  // must not disturb the accepted conversion
    n = 0; n_busy = 0;
    while (bif.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
      if (bif.busy === 1'b1) n_busy++;
    end
    total++; if (n != 17) begin bad++; $display("FAIL basic_latency: got done on cycle %0d, required 17", n); end
    total++; if (n_busy != 16) begin bad++; $display("FAIL basic_busy_cycles: got %0d, required 16", n_busy); end
    @(negedge clk);
    total++; if (bif.ready !== 1'b1 || bif.done !== 1'b0) begin
      bad++; $display("FAIL basic_after_done: got ready=%b done=%b, required ready=1 done=0", bif.ready, bif.done);
    end
    total++; if (bif.bin_out !== e[13:0]) begin bad++; $display("FAIL basic_hold: got %0d, required %0d", bif.bin_out, e[13:0]); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals[3];
    int acc[3];
    int n;
    vals[0] = 16'h9999; vals[1] = 16'h0000; vals[2] = 16'h0815;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (bif.ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      if (bif.ready !== 1'b1) begin
        total++; bad++; $display("FAIL b2b_ready_timeout: got ready=%b, required 1", bif.ready);
      end
      drive_start(vals[i], 1'b1, model(vals[i]));
      acc[i] = cyc;
    end
    for (int i = 1; i < 3; i++) begin
      total++; if (acc[i] - acc[i-1] != 18) begin
        bad++; $display("FAIL b2b_spacing: got %0d cycles, required 18", acc[i] - acc[i-1]);
      end
    end
    n = 0;
    while (bif.done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
  endtask

  task automatic test_ignore_busy();
    int d0, n;
    d0 = done_cnt;
    drive_start(16'h0042, 1'b1, model(16'h0042));
    repeat (5) @(negedge clk);
    bif.start  = 1'b1;
    bif.bcd_in = 16'h9999;
    repeat (4) @(negedge clk);
    bif.start = 1'b0;
    n = 0;
    while (bif.done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    repeat (20) @(negedge clk);
    total++; if (done_cnt != d0 + 1) begin
      bad++; $display("FAIL ignore_done_count: got %0d pulses, required 1", done_cnt - d0);
    end
    total++; if (bif.bin_out !== 14'd42) begin bad++; $display("FAIL ignore_bin: got %0d, required 42", bif.bin_out); end
  endtask

  task automatic test_reset_mid();
    int d0, n;
    drive_start(16'h5678, 1'b0, 15'd0);
    repeat (8) @(negedge clk);
    total++; if (bif.busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b, required 1", bif.busy); end
    #1 rst_n = 1'b0;
    #1;
    total++; if (bif.ready !== 1'b1 || bif.busy !== 1'b0 || bif.done !== 1'b0) begin
      bad++; $display("FAIL mid_reset_state: got ready=%b busy=%b done=%b, required 1 0 0",
                      bif.ready, bif.busy, bif.done);
    end
    total++; if (bif.bin_out !== 14'd0 || bif.err !== 1'b0) begin
      bad++; $display("FAIL mid_reset_out: got bin_out=%0d err=%b, required 0 0", bif.bin_out, bif.err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    total++; if (done_cnt != d0) begin bad++; $display("FAIL mid_no_done: got %0d pulses, required 0", done_cnt - d0); end
    drive_start(16'h0007, 1'b1, model(16'h0007));
    n = 0;
    while (bif.done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    total++; if (bif.done !== 1'b1) begin bad++; $display("FAIL mid_fresh_timeout: got done=%b, required 1", bif.done); end
    @(negedge clk);
  endtask

`ifdef BCD_DIGIT_CHECK_EN
  task automatic test_digit_check();
    int n;
    drive_start(16'h12A4, 1'b1, {1'b1, 14'd0});
    @(negedge clk);
    total++; if (bif.done !== 1'b1 || bif.err !== 1'b1) begin
      bad++; $display("FAIL check_fast_done: got done=%b err=%b, required 1 1", bif.done, bif.err);
    end
    @(negedge clk);
    drive_start(16'h0010, 1'b1, model(16'h0010));
    n = 0;
    while (bif.done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    total++; if (bif.err !== 1'b0) begin bad++; $display("FAIL check_err_clear: got %b, required 0", bif.err); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
`ifdef BCD_DIGIT_CHECK_EN
    test_digit_check();
`endif
    total++; if (sbq.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
